frac_interp: RTL and testbench

Horizontal fractional-pel interpolator feeding `frac_search`. Accepts a line of reference luma as 8-pixel chunks, applies the 8-tap HEVC luma filter with edge replication, and emits each filtered 8-pixel row together with its aligned integer-pel row. Its outputs `filter_pix`, `ref_pix` and `out_valid` connect directly to `frac_search`'s `filter_pix`, `ref_pix` and `input_ready`.

---
 rtl/frac_pkg.sv | 50 +++++
 rtl/frac_tap8.sv | 37 +++
 rtl/frac_interp.sv | 131 +++++++++++++
 tb/tb_frac_interp.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frac_pkg.sv
// frac_pkg: shared constants for the fractional-pel interpolator.
// Holds the tap sets for each phase, the arithmetic widths and the FSM encodings.
package frac_pkg;

  localparam int unsigned FRAC_PIX_W  = 8;
  localparam int unsigned FRAC_TAPS   = 8;
  localparam int unsigned FRAC_CTX    = 3;   // left context pixels kept
  localparam int unsigned FRAC_LOOK   = 4;   // lookahead pixels from next chunk
  localparam int unsigned FRAC_COEF_W = 8;
  localparam int unsigned FRAC_SUM_W  = 16;
  localparam int unsigned FRAC_RND_SH = 6;

  localparam logic signed [FRAC_SUM_W-1:0] FRAC_RND_OFS = 16'sd32;
  localparam logic signed [FRAC_SUM_W-1:0] FRAC_CLIP_LO = 16'sd0;
  localparam logic signed [FRAC_SUM_W-1:0] FRAC_CLIP_HI = 16'sd255;

  // Phase encodings (frac_sel)
  localparam logic [1:0] PH_INT   = 2'd0;
  localparam logic [1:0] PH_QPEL  = 2'd1;
  localparam logic [1:0] PH_HPEL  = 2'd2;
  localparam logic [1:0] PH_TQPEL = 2'd3;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef logic signed [FRAC_COEF_W-1:0] coef_t;

  // Tap k multiplies pixel x-3+k; integer copy is a unit tap on pixel x.
  localparam coef_t TAPS_INT [FRAC_TAPS] =
    '{8'sd0, 8'sd0, 8'sd0, 8'sd64, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
  localparam coef_t TAPS_QPEL [FRAC_TAPS] =
    '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};
  localparam coef_t TAPS_HPEL [FRAC_TAPS] =
    '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
  localparam coef_t TAPS_TQPEL [FRAC_TAPS] =
    '{8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};

  // Coefficient lookup by phase and tap index
  function automatic coef_t tap_coef(input logic [1:0] phase, input logic [2:0] k);
    case (phase)
      PH_INT:  tap_coef = TAPS_INT[k];
      PH_QPEL: tap_coef = TAPS_QPEL[k];
      PH_HPEL: tap_coef = TAPS_HPEL[k];
      default: tap_coef = TAPS_TQPEL[k];
    endcase
  endfunction

endpackage

// File: rtl/frac_tap8.sv
// frac_tap8: combinational 8-tap MAC with rounding and 0..255 clipping.
// win holds pixels x-3..x+4, pixel x-3 in the low bits.
module frac_tap8
  import frac_pkg::*;
(
  input  logic [FRAC_TAPS*FRAC_PIX_W-1:0] win,
  input  logic [1:0]                      phase,
  output logic [FRAC_PIX_W-1:0]           result_c
);

  logic signed [FRAC_SUM_W-1:0] sum;
  logic signed [FRAC_SUM_W-1:0] coef_ext;
  logic signed [FRAC_SUM_W-1:0] px_ext;
  logic signed [FRAC_SUM_W-1:0] rnd;
  logic signed [FRAC_SUM_W-1:0] shifted;

  // Multiply-accumulate, round, arithmetic shift and clip
  always_comb begin
    sum      = '0;
    coef_ext = '0;
    px_ext   = '0;
    for (int k = 0; k < int'(FRAC_TAPS); k++) begin
      coef_ext = FRAC_SUM_W'(tap_coef(phase, 3'(k)));
      px_ext   = signed'(FRAC_SUM_W'(win[k*FRAC_PIX_W +: FRAC_PIX_W]));
      sum      = sum + coef_ext * px_ext;
    end
    rnd     = sum + FRAC_RND_OFS;
    shifted = rnd >>> FRAC_RND_SH;
    if (shifted < FRAC_CLIP_LO)
      result_c = '0;
    else if (shifted > FRAC_CLIP_HI)
      result_c = '1;
    else
      result_c = shifted[FRAC_PIX_W-1:0];
  end

endmodule

// File: rtl/frac_interp.sv
// frac_interp: horizontal fractional-pel interpolator with edge replication.
// Optional macro FRAC_QPEL_EN adds frac_sel for integer/quarter/half/three-quarter phases;
// without it the filter is fixed at half-pel.
module frac_interp
  import frac_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned LANES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PIX_W*LANES-1:0] in_pix,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [PIX_W*LANES-1:0] filter_pix,
  output logic [PIX_W*LANES-1:0] ref_pix,
  output logic                   out_valid
`ifdef FRAC_QPEL_EN
  ,
  input  logic [1:0]             frac_sel
`endif
);

  localparam int unsigned ROW_W = PIX_W * LANES;
  localparam int unsigned CTX_W = PIX_W * FRAC_CTX;
  localparam int unsigned NXT_W = PIX_W * FRAC_LOOK;
  localparam int unsigned EXT_W = ROW_W + CTX_W + NXT_W;
  localparam int unsigned WIN_W = PIX_W * FRAC_TAPS;

  logic [1:0]       state_q, next_state;
  logic [ROW_W-1:0] held_q, held_d;
  logic [CTX_W-1:0] left_q, left_d;
  logic             ready_q;
  logic             out_valid_q;
  logic [ROW_W-1:0] filter_q, ref_q;

  logic             accept;
  logic             emit;
  logic [NXT_W-1:0] nxt4;
  logic [EXT_W-1:0] ext;
  logic [ROW_W-1:0] filt_c;
  logic [1:0]       phase;

`ifdef FRAC_QPEL_EN
  assign phase = frac_sel;
`else
  assign phase = PH_HPEL;
`endif

  // Pixel j of ext is line pixel j-3 relative to the held chunk
  assign ext = {nxt4, held_q, left_q};

  // One filter per output lane, each seeing its own 8-pixel window
  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    frac_tap8 u_tap (
      .win      (ext[g*PIX_W +: WIN_W]),
      .phase    (phase),
      .result_c (filt_c[g*PIX_W +: PIX_W])
    );
  end

  // Next-state, context update and emit decision
  always_comb begin
    next_state = state_q;
    held_d     = held_q;
    left_d     = left_q;
    emit       = 1'b0;
    nxt4       = {FRAC_LOOK{held_q[ROW_W-1 -: PIX_W]}};
    accept     = in_valid && ready_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          held_d     = in_pix;
          left_d     = {FRAC_CTX{in_pix[PIX_W-1:0]}};
          next_state = in_last ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          emit       = 1'b1;
          nxt4       = in_pix[NXT_W-1:0];
          left_d     = held_q[ROW_W-CTX_W +: CTX_W];
          held_d     = in_pix;
          next_state = in_last ? ST_FLUSH : ST_RUN;
        end
      end
      ST_FLUSH: begin
        emit       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State and context registers; ready is precomputed from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      held_q  <= '0;
      left_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= next_state;
      held_q  <= held_d;
      left_q  <= left_d;
      ready_q <= (next_state != ST_FLUSH);
    end
  end

  // Output registers; rows hold their value between strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      filter_q    <= '0;
      ref_q       <= '0;
    end else begin
      out_valid_q <= emit;
      if (emit) begin
        filter_q <= filt_c;
        ref_q    <= held_q;
      end
    end
  end

  assign in_ready   = ready_q;
  assign out_valid  = out_valid_q;
  assign filter_pix = filter_q;
  assign ref_pix    = ref_q;

endmodule

// File: tb/tb_frac_interp.sv
// tb_frac_interp: directed self-checking bench for frac_interp.
module tb_frac_interp;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in_pix = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [63:0] filter_pix;
  logic [63:0] ref_pix;
  logic        out_valid;
`ifdef FRAC_QPEL_EN
  logic [1:0]  frac_sel = 2'd2;
`endif

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  logic [63:0] sq_filter[$];
  logic [63:0] sq_ref[$];
  int          sq_cyc[$];
  int          rdy_lo[$];

  frac_interp dut (
    .clk        (clk),
    .reset      (reset),
    .in_pix     (in_pix),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .filter_pix (filter_pix),
    .ref_pix    (ref_pix),
    .out_valid  (out_valid)
`ifdef FRAC_QPEL_EN
    ,
    .frac_sel   (frac_sel)
`endif
  );

  always #5 clk = ~clk;

  // Posedge index counter
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe and ready-low logger
  always @(negedge clk) begin
    if (reset && out_valid) begin
      sq_filter.push_back(filter_pix);
      sq_ref.push_back(ref_pix);
      sq_cyc.push_back(cyc);
    end
    if (reset && !in_ready) rdy_lo.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic clear_logs();
    sq_filter.delete();
    sq_ref.delete();
    sq_cyc.delete();
    rdy_lo.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one chunk at a negedge; returns the posedge index it is accepted on
  task automatic send_chunk(input logic [63:0] pix, input logic last, output int acc_cyc);
    int guard;
    guard = 0;
    in_pix = pix;
    in_last = last;
    in_valid = 1'b1;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      n_total++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
    end
    acc_cyc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle(2);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++;
    if (filter_pix !== 64'h0) $display("FAIL rst_filter: got %h want 0", filter_pix); else n_pass++;
    n_total++;
    if (ref_pix !== 64'h0) $display("FAIL rst_ref: got %h want 0", ref_pix); else n_pass++;
    reset = 1'b1;
    idle(1);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_flat();
    int a;
    clear_logs();
    send_chunk({8{8'h80}}, 1'b0, a);
    send_chunk({8{8'h80}}, 1'b1, a);
    idle(4);
    n_total++;
    if (sq_filter.size() !== 2) $display("FAIL flat_count: got %0d want 2", sq_filter.size()); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (sq_filter[i] !== {8{8'h80}}) $display("FAIL flat_filter%0d: got %h want %h", i, sq_filter[i], {8{8'h80}}); else n_pass++;
      n_total++;
      if (sq_ref[i] !== {8{8'h80}}) $display("FAIL flat_ref%0d: got %h want %h", i, sq_ref[i], {8{8'h80}}); else n_pass++;
    end
  endtask

  task automatic test_step_edge();
    int a;
    logic [63:0] row_a, row_b;
    // Lane 0 in the low byte. Row B lane 0: taps 3..7 on 0xFF sum to 72 -> 287, clipped.
    row_a = 64'h8000_0C00_0000_0000;
    row_b = 64'hFFFF_FFFF_FFFF_F3FF;
    clear_logs();
    send_chunk(64'h0, 1'b0, a);
    send_chunk({8{8'hFF}}, 1'b1, a);
    idle(4);
    n_total++;
    if (sq_filter.size() !== 2) $display("FAIL step_count: got %0d want 2", sq_filter.size()); else n_pass++;
    n_total++;
    if (sq_filter[0] !== row_a) $display("FAIL step_row_a: got %h want %h", sq_filter[0], row_a); else n_pass++;
    n_total++;
    if (sq_ref[0] !== 64'h0) $display("FAIL step_ref_a: got %h want 0", sq_ref[0]); else n_pass++;
    n_total++;
    if (sq_filter[1] !== row_b) $display("FAIL step_row_b: got %h want %h", sq_filter[1], row_b); else n_pass++;
    n_total++;
    if (sq_ref[1] !== {8{8'hFF}}) $display("FAIL step_ref_b: got %h want %h", sq_ref[1], {8{8'hFF}}); else n_pass++;
  endtask

  task automatic test_flush_bubble();
    int a1, a2, a3;
    clear_logs();
    send_chunk({8{8'h20}}, 1'b0, a1);
    send_chunk({8{8'h21}}, 1'b0, a2);
    send_chunk({8{8'h22}}, 1'b1, a3);
    idle(4);
    n_total++;
    if (a2 !== a1 + 1) $display("FAIL bubble_accept2: got cycle %0d want %0d", a2, a1 + 1); else n_pass++;
    n_total++;
    if (a3 !== a2 + 1) $display("FAIL bubble_accept3: got cycle %0d want %0d", a3, a2 + 1); else n_pass++;
    n_total++;
    if (sq_cyc.size() !== 3) $display("FAIL bubble_count: got %0d want 3", sq_cyc.size()); else n_pass++;
    n_total++;
    if (sq_cyc[0] !== a2) $display("FAIL bubble_strobe0: got cycle %0d want %0d", sq_cyc[0], a2); else n_pass++;
    n_total++;
    if (sq_cyc[1] !== a3) $display("FAIL bubble_strobe1: got cycle %0d want %0d", sq_cyc[1], a3); else n_pass++;
    n_total++;
    if (sq_cyc[2] !== a3 + 1) $display("FAIL bubble_strobe2: got cycle %0d want %0d", sq_cyc[2], a3 + 1); else n_pass++;
    n_total++;
    if (rdy_lo.size() !== 1) $display("FAIL bubble_ready_len: got %0d low cycles want 1", rdy_lo.size()); else n_pass++;
    n_total++;
    if (rdy_lo[0] !== a3) $display("FAIL bubble_ready_at: got cycle %0d want %0d", rdy_lo[0], a3); else n_pass++;
    n_total++;
    if (sq_ref[2] !== {8{8'h22}}) $display("FAIL bubble_ref2: got %h want %h", sq_ref[2], {8{8'h22}}); else n_pass++;
  endtask

  task automatic test_single_chunk();
    int a;
    logic [63:0] ramp;
    logic [63:0] row;
    ramp = 64'h7060_5040_3020_1000;
    clear_logs();
    send_chunk(ramp, 1'b1, a);
    idle(4);
    n_total++;
    if (sq_filter.size() !== 1) $display("FAIL single_count: got %0d want 1", sq_filter.size()); else n_pass++;
    row = sq_filter[0];
    n_total++;
    if (sq_ref[0] !== ramp) $display("FAIL single_ref: got %h want %h", sq_ref[0], ramp); else n_pass++;
    n_total++;
    if (row[31:24] !== 8'h38) $display("FAIL single_lane3: got %h want 38", row[31:24]); else n_pass++;
    n_total++;
    if (row[39:32] !== 8'h48) $display("FAIL single_lane4: got %h want 48", row[39:32]); else n_pass++;
    n_total++;
    if (row[7:0] !== 8'h07) $display("FAIL single_lane0: got %h want 07", row[7:0]); else n_pass++;
    n_total++;
    if (row[63:56] !== 8'h72) $display("FAIL single_lane7: got %h want 72", row[63:56]); else n_pass++;
  endtask

  task automatic test_reset_midline();
    int a;
    send_chunk({8{8'h55}}, 1'b0, a);
    send_chunk({8{8'h66}}, 1'b0, a);
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL midrst_pre_strobe: got %b want 1", out_valid); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++;
    if (filter_pix !== 64'h0) $display("FAIL midrst_filter: got %h want 0", filter_pix); else n_pass++;
    n_total++;
    if (ref_pix !== 64'h0) $display("FAIL midrst_ref: got %h want 0", ref_pix); else n_pass++;
    idle(2);
    reset = 1'b1;
    clear_logs();
    idle(1);
    send_chunk({8{8'h40}}, 1'b0, a);
    send_chunk({8{8'h40}}, 1'b1, a);
    idle(4);
    n_total++;
    if (sq_filter.size() !== 2) $display("FAIL midrst_count: got %0d want 2", sq_filter.size()); else n_pass++;
    n_total++;
    if (sq_filter[0] !== {8{8'h40}}) $display("FAIL midrst_row0: got %h want %h", sq_filter[0], {8{8'h40}}); else n_pass++;
    n_total++;
    if (sq_filter[1] !== {8{8'h40}}) $display("FAIL midrst_row1: got %h want %h", sq_filter[1], {8{8'h40}}); else n_pass++;
    n_total++;
    if (sq_ref[0] !== {8{8'h40}}) $display("FAIL midrst_ref0: got %h want %h", sq_ref[0], {8{8'h40}}); else n_pass++;
  endtask

`ifdef FRAC_QPEL_EN
  task automatic test_qpel_int_copy();
    int a;
    logic [63:0] c0, c1;
    c0 = {$urandom, $urandom};
    c1 = {$urandom, $urandom};
    frac_sel = 2'd0;
    clear_logs();
    send_chunk(c0, 1'b0, a);
    send_chunk(c1, 1'b1, a);
    idle(4);
    n_total++;
    if (sq_filter.size() !== 2) $display("FAIL qpel_count: got %0d want 2", sq_filter.size()); else n_pass++;
    n_total++;
    if (sq_filter[0] !== c0) $display("FAIL qpel_copy0: got %h want %h", sq_filter[0], c0); else n_pass++;
    n_total++;
    if (sq_filter[1] !== c1) $display("FAIL qpel_copy1: got %h want %h", sq_filter[1], c1); else n_pass++;
    frac_sel = 2'd2;
  endtask
`endif

  initial begin
    test_reset();
    test_flat();
    test_step_edge();
    test_flush_bubble();
    test_single_chunk();
    test_reset_midline();
`ifdef FRAC_QPEL_EN
    test_qpel_int_copy();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
